// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M sequential multiply/divide unit.
// Latency: n/a (constants, state encodings and one helper function).
// Backpressure: n/a.
package rv32m_pkg;

  // funct3 encodings of the M extension
  localparam logic [2:0] m_mul    = 3'd0;
  localparam logic [2:0] m_mulh   = 3'd1;
  localparam logic [2:0] m_mulhsu = 3'd2;
  localparam logic [2:0] m_mulhu  = 3'd3;
  localparam logic [2:0] m_div    = 3'd4;
  localparam logic [2:0] m_divu   = 3'd5;
  localparam logic [2:0] m_rem    = 3'd6;
  localparam logic [2:0] m_remu   = 3'd7;

  // Number of one-bit iterations per operation
  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    md_idle = 2'd0,
    md_calc = 2'd1,
    md_done = 2'd2
  } md_state_t;

  // Magnitude of an operand: negate only when it is treated as signed and is negative
  function automatic logic [31:0] md_mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/rv32m_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Latency: purely combinational.
// Backpressure: none; the caller registers the outputs.
module rv32m_div_step (
  input  logic [32:0] rem_in,
  input  logic        dvd_bit,
  input  logic [31:0] divisor,
  output logic [32:0] rem_out,
  output logic        q_bit
);

  logic [32:0] shifted;
  logic [32:0] diff;

  assign shifted = {rem_in[31:0], dvd_bit};
  assign diff    = shifted - {1'b0, divisor};
  // A set top bit in the incoming remainder means the shifted value exceeds any divisor
  assign q_bit   = rem_in[32] | ~diff[32];
  assign rem_out = q_bit ? diff : shifted;

endmodule

// File: rtl/rv32m_seq_muldiv.sv
// RV32M multiply/divide responder: one bit per clock on operand magnitudes, sign-fixed at the end.
// Latency: 33 clocks from START sample to READY (1 clock for divide-by-zero / overflow divides).
// Backpressure: result and READY held in DONE until STALL_M_STD; START low anywhere aborts.
module rv32m_seq_muldiv
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            START,
  input  logic [2:0]      M_CNT,
  input  logic [XLEN-1:0] RS1,
  input  logic [XLEN-1:0] RS2,
  input  logic            STALL_M_STD,
  output logic [XLEN-1:0] OUT,
  output logic            READY
);

  md_state_t   state;
  logic [5:0]  cnt;
  logic [2:0]  op;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        neg_prod;
  logic        neg_q;
  logic        neg_r;
  logic [63:0] prod;
  logic [32:0] rem;
  logic [31:0] quo;

  // Request decode, only meaningful while idle
  logic        s1_sgn;
  logic        s2_sgn;
  logic        n1;
  logic        n2;
  logic        div0;
  logic        ovf;
  logic [31:0] special_res;
  logic [31:0] rs1_mag;
  logic [31:0] rs2_mag;

  assign s1_sgn  = (M_CNT == m_mul) || (M_CNT == m_mulh) || (M_CNT == m_mulhsu) ||
                   (M_CNT == m_div) || (M_CNT == m_rem);
  assign s2_sgn  = (M_CNT == m_mul) || (M_CNT == m_mulh) ||
                   (M_CNT == m_div) || (M_CNT == m_rem);
  assign n1      = s1_sgn & RS1[31];
  assign n2      = s2_sgn & RS2[31];
  assign rs1_mag = md_mag(RS1, s1_sgn);
  assign rs2_mag = md_mag(RS2, s2_sgn);
  assign div0    = M_CNT[2] && (RS2 == 32'd0);
  assign ovf     = ((M_CNT == m_div) || (M_CNT == m_rem)) &&
                   (RS1 == 32'h8000_0000) && (RS2 == 32'hFFFF_FFFF);
  // M_CNT[1] distinguishes the remainder ops from the quotient ops
  assign special_res = div0 ? (M_CNT[1] ? RS1 : 32'hFFFF_FFFF)
                            : (M_CNT[1] ? 32'd0 : 32'h8000_0000);

  // Multiply step: add multiplicand when the product's low bit is set, then shift right
  logic [32:0] mul_sum;
  logic [63:0] prod_nx;
  assign mul_sum = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, a_mag} : 33'd0);
  assign prod_nx = {mul_sum, prod[31:1]};

  // Divide step: quotient register starts as the dividend and shifts its bits out at the top
  logic [32:0] rem_nx;
  logic        q_bit;
  logic [31:0] quo_nx;

  rv32m_div_step u_div_step (
    .rem_in  (rem),
    .dvd_bit (quo[31]),
    .divisor (b_mag),
    .rem_out (rem_nx),
    .q_bit   (q_bit)
  );

  assign quo_nx = {quo[30:0], q_bit};

  // Sign correction and result selection applied on the final iteration
  logic [63:0] prod_fix;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] result;

  assign prod_fix = neg_prod ? (~prod_nx + 64'd1) : prod_nx;
  assign q_fix    = neg_q ? (~quo_nx + 32'd1) : quo_nx;
  assign r_fix    = neg_r ? (~rem_nx[31:0] + 32'd1) : rem_nx[31:0];

  // Pick the architectural result for the latched funct3
  always_comb begin
    result = r_fix;
    case (op)
      m_mul:                       result = prod_fix[31:0];
      m_mulh, m_mulhsu, m_mulhu:   result = prod_fix[63:32];
      m_div, m_divu:               result = q_fix;
      default:                     result = r_fix;
    endcase
  end

  // Control FSM with registered OUT/READY; iteration datapath advances in CALC
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= md_idle;
      cnt      <= 6'd0;
      op       <= m_mul;
      a_mag    <= 32'd0;
      b_mag    <= 32'd0;
      neg_prod <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      prod     <= 64'd0;
      rem      <= 33'd0;
      quo      <= 32'd0;
      OUT      <= '0;
      READY    <= 1'b0;
    end else begin
      case (state)
        md_idle: begin
          READY <= 1'b0;
          if (START) begin
            op       <= M_CNT;
            a_mag    <= rs1_mag;
            b_mag    <= rs2_mag;
            neg_prod <= n1 ^ n2;
            neg_q    <= n1 ^ n2;
            neg_r    <= n1;
            prod     <= {32'd0, rs2_mag};
            rem      <= 33'd0;
            quo      <= rs1_mag;
            cnt      <= 6'd0;
            if (div0 || ovf) begin
              OUT   <= special_res;
              READY <= 1'b1;
              state <= md_done;
            end else begin
              state <= md_calc;
            end
          end
        end
        md_calc: begin
          if (!START) begin
            state <= md_idle;
            OUT   <= '0;
            READY <= 1'b0;
          end else begin
            prod <= prod_nx;
            rem  <= rem_nx;
            quo  <= quo_nx;
            cnt  <= cnt + 6'd1;
            if (cnt == 6'(MD_ITER - 1)) begin
              OUT   <= result;
              READY <= 1'b1;
              state <= md_done;
            end
          end
        end
        md_done: begin
          if (!START) begin
            state <= md_idle;
            OUT   <= '0;
            READY <= 1'b0;
          end else if (STALL_M_STD) begin
            state <= md_idle;
            READY <= 1'b0;
          end
        end
        default: begin
          state <= md_idle;
          READY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_seq_muldiv.sv
// Directed plus random bench for rv32m_seq_muldiv against an arithmetic reference model.
// Latency: checks 33-clock normal and 1-clock special-divide READY timing.
// Backpressure: exercises result hold, consume, flush, async reset and back-to-back ops.
module tb_rv32m_seq_muldiv;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic [2:0]  M_CNT;
  logic [31:0] RS1;
  logic [31:0] RS2;
  logic        STALL_M_STD;
  logic [31:0] OUT;
  logic        READY;

  int n_pass = 0;
  int n_chk  = 0;

  rv32m_seq_muldiv #(.XLEN(32)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .START       (START),
    .M_CNT       (M_CNT),
    .RS1         (RS1),
    .RS2         (RS2),
    .STALL_M_STD (STALL_M_STD),
    .OUT         (OUT),
    .READY       (READY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Reference results straight from the RV32M definitions using 64-bit arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 32'd0) ||
           ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic stall);
    @(negedge CLK);
    M_CNT = op; RS1 = a; RS2 = b; START = 1'b1; STALL_M_STD = stall;
  endtask

  // Count edges until READY; operands are scrambled after the first edge to prove they are latched
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
      if (n == 1) begin
        RS1 = $urandom; RS2 = $urandom; M_CNT = 3'($urandom_range(0, 7));
      end
    end while (READY !== 1'b1 && n < 100);
  endtask

  task automatic consume(input string tag);
    @(negedge CLK); STALL_M_STD = 1'b1;
    @(posedge CLK); #1;
    chk({tag, " ready_drop"}, 32'(READY), 32'd0);
    @(negedge CLK); START = 1'b0; STALL_M_STD = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    int n;
    start_op(op, a, b, 1'b0);
    wait_ready(n);
    chk({tag, " latency"}, 32'(n), is_special(op, a, b) ? 32'd1 : 32'd33);
    chk({tag, " out"}, OUT, exp);
    consume(tag);
  endtask

  initial begin
    int n;
    int m;
    int hits;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    RST_N = 1'b0; START = 1'b0; STALL_M_STD = 1'b0; M_CNT = 3'd0; RS1 = 32'd0; RS2 = 32'd0;
    #12;
    chk("reset out", OUT, 32'd0);
    chk("reset ready", 32'(READY), 32'd0);
    @(negedge CLK); RST_N = 1'b1;

    // Directed arithmetic cases
    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul 7x-3");
    run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulh min");
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu max");
    run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div -7/2");
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem -7/2");
    run_op(3'd5, 32'h0000_DEAD,  32'd0,         32'hFFFF_FFFF, "divu by0");
    run_op(3'd7, 32'h0000_1234,  32'd0,         32'h0000_1234, "remu by0");
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div ovf");
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "rem ovf");

    // Result hold: STALL_M_STD low keeps DONE stable
    start_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    wait_ready(n);
    chk("hold latency", 32'(n), 32'd33);
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      chk("hold out", OUT, 32'hFFFF_FFEB);
      chk("hold ready", 32'(READY), 32'd1);
    end
    consume("hold");

    // Flush: drop START partway through CALC
    start_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    repeat (11) @(posedge CLK);
    @(negedge CLK); START = 1'b0;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (READY !== 1'b0) hits++;
    end
    chk("flush ready_seen", 32'(hits), 32'd0);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, "divu after flush");

    // Asynchronous reset mid-CALC clears the held previous result
    start_op(3'd0, 32'd3, 32'd5, 1'b0);
    repeat (10) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("async rst out", OUT, 32'd0);
    chk("async rst ready", 32'(READY), 32'd0);
    @(negedge CLK); START = 1'b0; RST_N = 1'b1;

    // Back-to-back: START and STALL_M_STD held high continuously
    start_op(3'd0, 32'd3, 32'd5, 1'b1);
    wait_ready(n);
    chk("b2b first latency", 32'(n), 32'd33);
    chk("b2b first out", OUT, 32'd15);
    @(negedge CLK); M_CNT = 3'd0; RS1 = 32'd3; RS2 = 32'd5;
    m = 0;
    do begin
      @(posedge CLK); #1;
      if (READY !== 1'b1) m++;
    end while (READY !== 1'b1 && m < 100);
    chk("b2b gap", 32'(m), 32'd33);
    chk("b2b second out", OUT, 32'd15);
    @(negedge CLK); START = 1'b0; STALL_M_STD = 1'b0;
    @(posedge CLK); #1;
    chk("b2b end ready", 32'(READY), 32'd0);

    // Random operations against the reference model, biased toward corner operands
    for (int k = 0; k < 30; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = -32'($urandom_range(1, 100));
        4: rb = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(rop, ra, rb, ref_md(rop, ra, rb), $sformatf("rand%0d op%0d", k, rop));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rv32m_seq_muldiv.md
# rv32m_seq_muldiv

Sequential RV32M multiply/divide responder for the execute stage. It accepts a held `START` request with funct3 and two operands, iterates one bit per clock, then presents the 32-bit result with `READY`. It holds that result until the pipeline advances. The execute stage drives `START`/`M_CNT`/`RS1`/`RS2`/`STALL_M_STD`, stalls on `START & !READY`, and selects `OUT` onto its writeback mux.

## Interface
- `XLEN`, 32: operand and result width. Only 32 is supported.
- `CLK` input 1: single clock. All state changes on the rising edge.
- `RST_N` input 1: reset, asynchronous and active-low.
- `START` input 1: M-extension op present in EX. Held high for the whole op. Deasserting it mid-op means flush.
- `M_CNT` input 3: funct3. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `RS1` input 32: rs1 operand. Signed or unsigned per `M_CNT`.
- `RS2` input 32: rs2 operand.
- `STALL_M_STD` input 1: EX advance enable. When high, the pipeline consumes the current result.
- `OUT` output 32: result. Valid while `READY`=1.
- `READY` output 1: result valid, registered.

## Operation
- State machine: IDLE, CALC, DONE.
- **IDLE**
  - If `START`=1 at an edge: latch `M_CNT`, `RS1`, `RS2`, the operand signs and the magnitudes.
  - Magnitudes: signed inputs are two's-complement negated when negative. Unsigned inputs are passed through.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - Clear the 6-bit iteration counter, then go to CALC.
  - **Special divides skip CALC** and go straight to DONE with the result loaded on that edge:
    - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
    - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: DIV gives 0x80000000, REM gives 0.
- **CALC, multiply**
  - Radix-2 shift-add on magnitudes into a 64-bit product register, 32 iterations.
- **CALC, divide**
  - Restoring division on magnitudes: 33-bit partial remainder, 32-bit quotient, 32 iterations.
- **CALC completion**
  - When the counter reaches 31, apply sign correction in the same edge and go to DONE.
  - Multiply product sign: sign(rs1) XOR sign(rs2), using only the signed operands.
  - Quotient sign: rs1 XOR rs2 signs. Remainder sign: rs1 sign.
  - Result selection: MUL takes low 32 bits; MULH/MULHSU/MULHU take high 32 bits; DIV/DIVU take the quotient; REM/REMU take the remainder.
- **DONE**
  - `READY`=1 and `OUT`=result.
  - If `STALL_M_STD`=1 at an edge: go to IDLE and drop `READY`.
  - A `START` still high on the following cycle belongs to the next instruction and starts a new op.
- **Abort:** `START`=0 in CALC or DONE → IDLE next edge, `READY`=0, no result retained.
- **Reset:** asserting `RST_N` low in any state → IDLE immediately, `READY`=0, `OUT`=0, counter=0.

## Timing
- Reset values: `OUT`=0x00000000, `READY`=0, state IDLE.
- Normal latency:
  - `START` sampled at edge E0.
  - CALC occupies edges E1–E32.
  - `READY`=1 from after E32, i.e. 33 clocks after first sample.
- Special-divide latency: `READY`=1 after E0 (1 clock).
- `READY` is a flop output with no combinational path from inputs.
- `OUT` is stable for the whole DONE residency.
- Operand or `M_CNT` changes after E0 are ignored until the next IDLE sample.
- `START` and `STALL_M_STD` both high in DONE: consume and go to IDLE. There is no same-edge restart.
- Minimum spacing of back-to-back ops: DONE→IDLE→new op costs 1 idle cycle.

## Structure
- Shared package `rv32m_pkg`:
  - funct3 constants `m_mul`…`m_remu`.
  - State encodings `md_idle`, `md_calc`, `md_done`.
  - `MD_ITER`=32.
- Pipeline enums stay in the existing pipeline params include.
- One natural sub-module: `rv32m_div_step`, a combinational single restoring-division step (33-bit subtract + quotient bit).
  - The multiply step stays inline.
- Target size is about 200 lines of RTL.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD → `OUT`=0xFFFFFFEB, `READY` rises exactly 33 clocks after `START`.
- MULH 0x80000000×0x80000000 → 0x40000000.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (−7), rs2=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF.
- Special cases, each with `READY` after 1 clock:
  - DIVU x/0 → 0xFFFFFFFF.
  - REMU 0x1234/0 → 0x1234.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Flush and result hold:
  - Drop `START` at CALC cycle 10 → `READY` stays 0, state returns to IDLE.
  - A new DIVU 100/7 then yields 14.
  - Holding `STALL_M_STD`=0 in DONE keeps `OUT`/`READY` stable for 5+ cycles.
- Reset and back-to-back:
  - Pulse `RST_N` low mid-CALC → `OUT`=0, `READY`=0 asynchronously.
  - MUL 3×5 with continuous `START` and `STALL_M_STD`=1 yields two results, 15 and 15, with 1 idle cycle between `READY` pulses.
